// File: rtl/dot_accel_pkg.sv
// Shared types and constants for the dot_accel Q16.16 dot-product engine.
// Register offsets, FSM encoding and address/length helpers live here.
package dot_accel_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned N_MAX      = 65535;

  typedef logic signed [DATA_W-1:0] q16_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_W,
    S_WT_W,
    S_RD_A,
    S_WT_A,
    S_ACC,
    S_DONE
  } state_e;

  localparam logic [REG_ADDR_W-1:0] REG_START = 3'd0;
  localparam logic [REG_ADDR_W-1:0] REG_WBASE = 3'd1;
  localparam logic [REG_ADDR_W-1:0] REG_ABASE = 3'd2;
  localparam logic [REG_ADDR_W-1:0] REG_LEN   = 3'd3;
  localparam logic [REG_ADDR_W-1:0] REG_BIAS  = 3'd4;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [DATA_W-1:0] n);
    if (n > DATA_W'(N_MAX)) return LEN_W'(N_MAX);
    return n[LEN_W-1:0];
  endfunction

  // Byte address of element idx; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/dot_accel_mul.sv
// q16_mul: combinational signed Q16.16 multiply, keeping product bits [47:16]
// (truncation toward minus infinity).
module q16_mul
  import dot_accel_pkg::*;
(
  input  q16_t a_i,
  input  q16_t b_i,
  output q16_t p_o
);

  logic [2*DATA_W-1:0]          a_ext;
  logic [2*DATA_W-1:0]          b_ext;
  logic [FRAC_BITS-1:0]         unused_hi;
  logic [FRAC_BITS-1:0]         unused_lo;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign {unused_hi, p_o, unused_lo} = a_ext * b_ext;

endmodule

// File: rtl/dot_accel.sv
// dot_accel: Avalon-MM dot-product engine, acc = bias + sum(w[i]*a[i]) in Q16.16.
// Define DOT_ACCEL_RELU_EN to clamp a negative final accumulator to zero.
module dot_accel
  import dot_accel_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] slave_address,
  input  logic                  slave_read,
  input  logic                  slave_write,
  input  logic [DATA_W-1:0]     slave_writedata,
  output logic [DATA_W-1:0]     slave_readdata,
  output logic                  slave_waitrequest,
  output logic [ADDR_W-1:0]     master_address,
  output logic                  master_read,
  input  logic                  master_waitrequest,
  input  logic [DATA_W-1:0]     master_readdata,
  input  logic                  master_readdatavalid
);

  state_e              state_q;
  logic [ADDR_W-1:0]   wbase_reg_q, abase_reg_q;
  logic [DATA_W-1:0]   len_reg_q, bias_reg_q;
  logic [ADDR_W-1:0]   w_base_q, a_base_q;
  logic [LEN_W-1:0]    len_q, idx_q, idx_d;
  q16_t                acc_q, w_q, a_q, prod;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                master_read_q;
  logic [ADDR_W-1:0]   master_address_q;
  logic                start;

  q16_mul u_mul (
    .a_i (w_q),
    .b_i (a_q),
    .p_o (prod)
  );

  assign start = slave_write && (slave_address == REG_START);
  assign idx_d = idx_q + LEN_W'(1);

`ifdef DOT_ACCEL_RELU_EN
  assign result_d = acc_q[DATA_W-1] ? '0 : acc_q;
`else
  assign result_d = acc_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      wbase_reg_q      <= '0;
      abase_reg_q      <= '0;
      len_reg_q        <= '0;
      bias_reg_q       <= '0;
      w_base_q         <= '0;
      a_base_q         <= '0;
      len_q            <= '0;
      idx_q            <= '0;
      acc_q            <= '0;
      w_q              <= '0;
      a_q              <= '0;
      result_q         <= '0;
      master_read_q    <= 1'b0;
      master_address_q <= '0;
    end else begin
      // Programmed registers accept writes at any time; they only feed the next start.
      if (slave_write) begin
        case (slave_address)
          REG_WBASE: wbase_reg_q <= slave_writedata;
          REG_ABASE: abase_reg_q <= slave_writedata;
          REG_LEN:   len_reg_q   <= slave_writedata;
          REG_BIAS:  bias_reg_q  <= slave_writedata;
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_base_q <= wbase_reg_q;
            a_base_q <= abase_reg_q;
            len_q    <= clamp_len(len_reg_q);
            acc_q    <= bias_reg_q;
            idx_q    <= '0;
            if (len_reg_q == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q          <= S_RD_W;
              master_read_q    <= 1'b1;
              master_address_q <= wbase_reg_q;
            end
          end
        end
        S_RD_W: begin
          if (!master_waitrequest) begin
            master_read_q <= 1'b0;
            state_q       <= S_WT_W;
          end
        end
        S_WT_W: begin
          if (master_readdatavalid) begin
            w_q              <= master_readdata;
            state_q          <= S_RD_A;
            master_read_q    <= 1'b1;
            master_address_q <= elem_addr(a_base_q, idx_q);
          end
        end
        S_RD_A: begin
          if (!master_waitrequest) begin
            master_read_q <= 1'b0;
            state_q       <= S_WT_A;
          end
        end
        S_WT_A: begin
          if (master_readdatavalid) begin
            a_q     <= master_readdata;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          acc_q <= acc_q + prod;
          idx_q <= idx_d;
          if (idx_d == len_q) begin
            state_q <= S_DONE;
          end else begin
            state_q          <= S_RD_W;
            master_read_q    <= 1'b1;
            master_address_q <= elem_addr(w_base_q, idx_d);
          end
        end
        S_DONE: begin
          result_q <= result_d;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign master_read    = master_read_q;
  assign master_address = master_address_q;

  // Result reads stall while a run is in flight; everything else answers at once.
  always_comb begin
    slave_readdata    = '0;
    slave_waitrequest = 1'b0;
    if (slave_read) begin
      case (slave_address)
        REG_START: begin
          if (state_q != S_IDLE) slave_waitrequest = 1'b1;
          else                   slave_readdata    = result_q;
        end
        REG_WBASE: slave_readdata = wbase_reg_q;
        REG_ABASE: slave_readdata = abase_reg_q;
        REG_LEN:   slave_readdata = len_reg_q;
        REG_BIAS:  slave_readdata = bias_reg_q;
        default:   slave_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accel.sv
// Self-checking bench for dot_accel: SDRAM responder with random stalls and
// latency, plus an arithmetic reference for the Q16.16 dot product.
module tb_dot_accel;

  localparam int TMO = 20000;
`ifdef DOT_ACCEL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  slave_address;
  logic        slave_read, slave_write;
  logic [31:0] slave_writedata, slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] master_address;
  logic        master_read, master_waitrequest;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;

  int total = 0;
  int bad   = 0;

  dot_accel dut (
    .clk                  (clk),
    .reset                (reset),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .slave_waitrequest    (slave_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM responder
  logic [31:0] mem [bit [31:0]];
  int          wait_pct = 0, lat_min = 1, lat_max = 1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          prev_stall = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_addr = '0;
  int          stall_viol = 0, read_cycles = 0;

  initial begin
    master_waitrequest   = 1'b0;
    master_readdata      = '0;
    master_readdatavalid = 1'b0;
  end

  always @(negedge clk) begin
    if (prev_stall && !reset && !prev_rst &&
        (master_read !== 1'b1 || master_address !== prev_addr)) stall_viol++;
    if (master_read === 1'b1) read_cycles++;
    master_readdatavalid = 1'b0;
    master_readdata      = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend                 = 1'b0;
        master_readdatavalid = 1'b1;
        master_readdata      = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
      end
    end
    master_waitrequest = (int'($urandom_range(99)) < wait_pct);
    if (master_read === 1'b1 && !master_waitrequest && !pend && !reset) begin
      pend      = 1'b1;
      pend_cnt  = int'($urandom_range(lat_max, lat_min));
      pend_addr = master_address;
    end
    prev_stall = (master_read === 1'b1) && master_waitrequest;
    prev_addr  = master_address;
    prev_rst   = reset;
  end

  function automatic logic [31:0] golden(input logic [31:0] w[$], input logic [31:0] a[$],
                                         input logic [31:0] bias);
    logic [31:0] acc;
    longint      p;
    acc = bias;
    for (int i = 0; i < w.size(); i++) begin
      p   = (longint'($signed(w[i])) * longint'($signed(a[i]))) >>> 16;
      acc = acc + p[31:0];
    end
    if (RELU && acc[31]) acc = '0;
    return acc;
  endfunction

  task automatic slave_wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    slave_address   = addr;
    slave_writedata = data;
    slave_write     = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic slave_rd(input logic [2:0] addr, output logic [31:0] data, output int waits);
    @(negedge clk);
    slave_address = addr;
    slave_read    = 1'b1;
    #1;
    waits = 0;
    while (slave_waitrequest === 1'b1 && waits < TMO) begin
      @(negedge clk); #1;
      waits++;
    end
    data = slave_readdata;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  task automatic load_mem(input logic [31:0] base, input logic [31:0] d[$]);
    for (int i = 0; i < d.size(); i++) mem[base + 32'(4 * i)] = d[i];
  endtask

  task automatic program_regs(input logic [31:0] wb, input logic [31:0] ab,
                              input logic [31:0] n, input logic [31:0] bias);
    slave_wr(3'd1, wb);
    slave_wr(3'd2, ab);
    slave_wr(3'd3, n);
    slave_wr(3'd4, bias);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int          w;
    reset = 1'b1;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (master_read !== 1'b0) begin bad++; $display("FAIL reset_mread got=%b want=0", master_read); end
    total++; if (master_address !== 32'h0) begin bad++; $display("FAIL reset_maddr got=%h want=0", master_address); end
    total++; if (slave_waitrequest !== 1'b0) begin bad++; $display("FAIL reset_swait got=%b want=0", slave_waitrequest); end
    total++; if (slave_readdata !== 32'h0) begin bad++; $display("FAIL reset_srdata got=%h want=0", slave_readdata); end
    reset = 1'b0;
    for (int r = 0; r < 6; r++) begin
      slave_rd(3'(r), d, w);
      total++;
      if (d !== 32'h0 || w != 0) begin
        bad++; $display("FAIL reset_reg%0d got=%h waits=%0d want=0 waits=0", r, d, w);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] wv[$], av[$], d;
    int          w;
    wait_pct = 0; lat_min = 2; lat_max = 2;
    wv = '{32'h0001_0000, 32'h0002_0000};
    av = '{32'h0003_0000, 32'h0000_8000};
    load_mem(32'h0000_1000, wv);
    load_mem(32'h0000_2000, av);
    program_regs(32'h0000_1000, 32'h0000_2000, 32'd2, 32'h0);
    slave_wr(3'd0, 32'h0);
    total++;
    if (master_read !== 1'b1 || master_address !== 32'h0000_1000) begin
      bad++; $display("FAIL basic_first_read got=%b/%h want=1/00001000", master_read, master_address);
    end
    slave_rd(3'd0, d, w);
    total++; if (d !== 32'h0004_0000) begin bad++; $display("FAIL basic_result got=%h want=00040000", d); end
    total++; if (w != 15) begin bad++; $display("FAIL basic_latency got=%0d want=15", w); end
    slave_rd(3'd0, d, w);
    total++;
    if (d !== 32'h0004_0000 || w != 0) begin
      bad++; $display("FAIL basic_idle_reread got=%h waits=%0d want=00040000 waits=0", d, w);
    end
    slave_rd(3'd2, d, w);
    total++;
    if (d !== 32'h0000_2000 || w != 0) begin
      bad++; $display("FAIL basic_abase_rb got=%h waits=%0d want=00002000 waits=0", d, w);
    end
    slave_wr(3'd3, 32'h0001_0005);
    slave_rd(3'd3, d, w);
    total++; if (d !== 32'h0001_0005) begin bad++; $display("FAIL len_unclamped_rb got=%h want=00010005", d); end
    slave_wr(3'd6, 32'hDEAD_BEEF);
    slave_rd(3'd6, d, w);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved_rb got=%h want=0", d); end
  endtask

  task automatic test_zero_len();
    logic [31:0] d;
    int          w, rc0;
    program_regs(32'h0000_1000, 32'h0000_2000, 32'd0, 32'h0005_0000);
    rc0 = read_cycles;
    slave_wr(3'd0, 32'h0);
    slave_rd(3'd0, d, w);
    total++; if (d !== 32'h0005_0000) begin bad++; $display("FAIL zero_result got=%h want=00050000", d); end
    total++; if (w != 1) begin bad++; $display("FAIL zero_waits got=%0d want=1", w); end
    total++; if (read_cycles != rc0) begin bad++; $display("FAIL zero_no_master_read got=%0d want=%0d", read_cycles, rc0); end
  endtask

  task automatic test_relu();
    logic [31:0] wv[$], av[$], d, exp_v;
    int          w;
    wv = '{32'h0001_0000};
    av = '{32'hFFFD_8000};
    exp_v = RELU ? 32'h0 : 32'hFFFD_8000;
    load_mem(32'h0000_4000, wv);
    load_mem(32'h0000_5000, av);
    program_regs(32'h0000_4000, 32'h0000_5000, 32'd1, 32'h0);
    slave_wr(3'd0, 32'h0);
    slave_rd(3'd0, d, w);
    total++; if (d !== exp_v) begin bad++; $display("FAIL relu_result got=%h want=%h", d, exp_v); end
  endtask

  task automatic test_random();
    logic [31:0] wv[$], av[$], d, bias, wb, exp_v;
    int          w;
    wait_pct = 50; lat_min = 1; lat_max = 8;
    stall_viol = 0;
    for (int j = 0; j < 3; j++) begin
      wv.delete(); av.delete();
      for (int i = 0; i < 16; i++) begin
        wv.push_back($urandom);
        av.push_back($urandom);
      end
      bias = $urandom;
      wb   = (j == 2) ? 32'hFFFF_FFF0 : 32'h0001_0000 + 32'(j * 32'h1000);
      load_mem(wb, wv);
      load_mem(32'h0008_0000, av);
      exp_v = golden(wv, av, bias);
      program_regs(wb, 32'h0008_0000, 32'd16, bias);
      slave_wr(3'd0, 32'h0);
      slave_rd(3'd0, d, w);
      total++;
      if (d !== exp_v || w >= TMO) begin
        bad++; $display("FAIL random_job%0d got=%h waits=%0d want=%h", j, d, w, exp_v);
      end
    end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stall_viol); end
  endtask

  task automatic test_busy();
    logic [31:0] w1[$], w2[$], av[$], d, e1, e2;
    int          w;
    wait_pct = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) begin
      w1.push_back($urandom); w2.push_back($urandom); av.push_back($urandom);
    end
    load_mem(32'h0002_0000, w1);
    load_mem(32'h0003_0000, w2);
    load_mem(32'h0004_0000, av);
    e1 = golden(w1, av, 32'h0000_1234);
    e2 = golden(w2, av, 32'h0000_1234);
    program_regs(32'h0002_0000, 32'h0004_0000, 32'd4, 32'h0000_1234);
    slave_wr(3'd0, 32'h0);
    slave_wr(3'd1, 32'h0003_0000);
    slave_wr(3'd0, 32'h0);
    slave_rd(3'd0, d, w);
    total++; if (d !== e1) begin bad++; $display("FAIL busy_run1 got=%h want=%h", d, e1); end
    slave_rd(3'd1, d, w);
    total++; if (d !== 32'h0003_0000) begin bad++; $display("FAIL busy_wbase_rb got=%h want=00030000", d); end
    slave_wr(3'd0, 32'h0);
    slave_rd(3'd0, d, w);
    total++; if (d !== e2) begin bad++; $display("FAIL busy_run2 got=%h want=%h", d, e2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wv[$], av[$], d, exp_v;
    int          w, n;
    wait_pct = 0; lat_min = 8; lat_max = 8;
    wv = '{32'h0001_8000, 32'hFFFF_0000};
    av = '{32'h0002_0000, 32'h0000_4000};
    load_mem(32'h0005_0000, wv);
    load_mem(32'h0006_0000, av);
    program_regs(32'h0005_0000, 32'h0006_0000, 32'd2, 32'h0000_0100);
    slave_wr(3'd0, 32'h0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!pend && n < 1000);
    total++; if (!pend) begin bad++; $display("FAIL rst_outstanding got=0 want=1"); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (master_read !== 1'b0 || master_address !== 32'h0 ||
        slave_waitrequest !== 1'b0 || slave_readdata !== 32'h0) begin
      bad++; $display("FAIL rst_outputs got=%b/%h/%b/%h want=0/0/0/0",
                      master_read, master_address, slave_waitrequest, slave_readdata);
    end
    reset = 1'b0;
    n = 0;
    while (pend && n < 1000) begin @(negedge clk); #1; n++; end
    repeat (2) @(negedge clk);
    #1;
    total++; if (master_read !== 1'b0) begin bad++; $display("FAIL rst_late_valid got=%b want=0", master_read); end
    slave_rd(3'd0, d, w);
    total++; if (d !== 32'h0 || w != 0) begin bad++; $display("FAIL rst_result got=%h waits=%0d want=0", d, w); end
    slave_rd(3'd1, d, w);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_wbase got=%h want=0", d); end
    exp_v = golden(wv, av, 32'h0000_0100);
    lat_min = 1; lat_max = 3;
    program_regs(32'h0005_0000, 32'h0006_0000, 32'd2, 32'h0000_0100);
    slave_wr(3'd0, 32'h0);
    slave_rd(3'd0, d, w);
    total++; if (d !== exp_v) begin bad++; $display("FAIL rst_recover got=%h want=%h", d, exp_v); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_relu();
    test_random();
    test_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
